// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage types: occupancy state encoding and control-field layout.
// Imported by every pipe_stage_reg file and by the stages that decode out_ctrl.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int CTRL_W_DEF = 8;

  // Bit positions inside the control field carried alongside the payload.
  localparam int CTRL_ZERO  = 0;
  localparam int CTRL_BR_LO = 1;
  localparam int CTRL_BR_HI = 2;
  localparam int CTRL_MEMR  = 3;
  localparam int CTRL_MEMW  = 4;
  localparam int CTRL_REGW  = 5;
  localparam int CTRL_MEM2R = 6;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: holds at all-ones, synchronous clear wins over increment.
// Latency 1 cycle; no backpressure (free-running on inc).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, optional 2-entry skid, flush, stall/bubble counters.
// Latency 1 cycle; backpressure via registered in_ready (skid absorbs one beat) or combinational in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic              w_accept;
  logic              w_emit;
  logic              w_main_ld;
  logic              w_main_from_skid;
  logic              w_skid_ld;
  logic              w_stall_inc;
  logic              w_bubble_inc;
  logic [DATA_W-1:0] r_main_dat;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_dat;
  logic [CTRL_W-1:0] r_skid_ctrl;

  // With the skid, ready depends only on the registered state so it can be timed as a flop output.
  assign out_valid = (r_state != EMPTY);
  assign in_ready  = SKID_EN ? (r_state != TWO) : (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_emit    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_main_ld   = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_emit) begin
          w_main_ld = 1'b1;
        end else if (w_accept && SKID_EN) begin
          w_state_nxt = TWO;
          w_skid_ld   = 1'b1;
        end else if (w_emit) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_emit) begin
          w_state_nxt      = ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = EMPTY;
    end
  end

  // Payload flops are never cleared by flush; only valid state and control are killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_dat <= '0;
    end else if (w_main_ld) begin
      r_main_dat <= in_data;
    end else if (w_main_from_skid) begin
      r_main_dat <= r_skid_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_dat <= '0;
    end else if (w_skid_ld) begin
      r_skid_dat <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_main_ld) begin
        r_main_ctrl <= in_ctrl;
      end else if (w_main_from_skid) begin
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_skid_ld) begin
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  assign out_data = r_main_dat;
  assign out_ctrl = out_valid ? r_main_ctrl : '0;

  assign w_stall_inc  = out_valid && !out_ready;
  assign w_bubble_inc = !out_valid && out_ready;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_bubble_inc),
    .clr   (cnt_clr),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (16-bit counters) and a no-skid instance (4-bit counters)
// driven in lockstep and compared every cycle against a queue-based occupancy model.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [CW-1:0] ctl;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]         iv, fl, ordy, clr;
  logic [1:0][DW-1:0] idat;
  logic [1:0][CW-1:0] ictl;

  logic          irdy_a, irdy_b, ov_a, ov_b;
  logic [DW-1:0] odat_a, odat_b;
  logic [CW-1:0] octl_a, octl_b;
  logic [15:0]   stall_a, bub_a;
  logic [3:0]    stall_b, bub_b;

  int checks = 0;
  int errors = 0;

  beat_t m_slot [2][2];
  int    m_cnt  [2];
  int    m_stall[2];
  int    m_bub  [2];
  logic  m_acc  [2];
  logic [DW-1:0] em_dut0[$], em_dut1[$], em_ref0[$], em_ref1[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .CNT_W(16)) u_dut_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy_a), .in_data(idat[0]),
    .in_ctrl(ictl[0]), .flush(fl[0]), .out_valid(ov_a), .out_ready(ordy[0]),
    .out_data(odat_a), .out_ctrl(octl_a), .cnt_clr(clr[0]), .stall_cnt(stall_a),
    .bubble_cnt(bub_a)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .CNT_W(4)) u_dut_noskid (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy_b), .in_data(idat[1]),
    .in_ctrl(ictl[1]), .flush(fl[1]), .out_valid(ov_b), .out_ready(ordy[1]),
    .out_data(odat_b), .out_ctrl(octl_b), .cnt_clr(clr[1]), .stall_cnt(stall_b),
    .bubble_cnt(bub_b)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int d, input logic v, input logic [DW-1:0] dat, input logic r,
                     input logic f = 1'b0, input logic c = 1'b0);
    iv[d]   = v;
    idat[d] = dat;
    ictl[d] = CW'($urandom);
    ordy[d] = r;
    fl[d]   = f;
    clr[d]  = c;
  endtask

  task automatic drv_both(input logic v, input logic [DW-1:0] dat, input logic r,
                          input logic f = 1'b0);
    drv(0, v, dat, r, f);
    drv(1, v, dat, r, f);
  endtask

  function automatic logic [DW-1:0] rnd_dat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Inputs are already applied just after a falling edge; check, advance the model, cross one rising edge.
  task automatic cycle();
    logic          r, v, e_v, e_r, emit;
    logic [DW-1:0] dq, st, bb;
    logic [CW-1:0] cq;
    int            cmax;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        r = irdy_a; v = ov_a; dq = odat_a; cq = octl_a;
        st = DW'(stall_a); bb = DW'(bub_a); cmax = 65535;
        e_r = (m_cnt[0] < 2);
      end else begin
        r = irdy_b; v = ov_b; dq = odat_b; cq = octl_b;
        st = DW'(stall_b); bb = DW'(bub_b); cmax = 15;
        e_r = (m_cnt[1] == 0) || ordy[1];
      end
      e_v = (m_cnt[d] > 0);
      chk($sformatf("d%0d_in_ready", d), DW'(r), DW'(e_r));
      chk($sformatf("d%0d_out_valid", d), DW'(v), DW'(e_v));
      chk($sformatf("d%0d_out_ctrl", d), DW'(cq), e_v ? DW'(m_slot[d][0].ctl) : DW'(0));
      if (e_v) chk($sformatf("d%0d_out_data", d), dq, m_slot[d][0].dat);
      chk($sformatf("d%0d_stall_cnt", d), st, DW'(m_stall[d]));
      chk($sformatf("d%0d_bubble_cnt", d), bb, DW'(m_bub[d]));

      if (v && ordy[d]) begin
        if (d == 0) em_dut0.push_back(dq); else em_dut1.push_back(dq);
      end
      emit     = e_v && ordy[d];
      m_acc[d] = iv[d] && e_r && !fl[d];
      if (clr[d]) m_stall[d] = 0;
      else if (e_v && !ordy[d] && m_stall[d] < cmax) m_stall[d]++;
      if (clr[d]) m_bub[d] = 0;
      else if (!e_v && ordy[d] && m_bub[d] < cmax) m_bub[d]++;
      if (emit) begin
        if (d == 0) em_ref0.push_back(m_slot[d][0].dat); else em_ref1.push_back(m_slot[d][0].dat);
        m_slot[d][0] = m_slot[d][1];
        m_cnt[d]--;
      end
      if (m_acc[d]) begin
        m_slot[d][m_cnt[d]] = '{dat: idat[d], ctl: ictl[d]};
        m_cnt[d]++;
      end
      if (fl[d]) m_cnt[d] = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv    = 2'b11;
    idat  = {rnd_dat(), rnd_dat()};
    ordy  = 2'b10;
    fl    = 2'b00;
    clr   = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid_a", DW'(ov_a), DW'(0));
    chk("rst_valid_b", DW'(ov_b), DW'(0));
    chk("rst_ctrl_a", DW'(octl_a), DW'(0));
    chk("rst_ctrl_b", DW'(octl_b), DW'(0));
    chk("rst_data_a", odat_a, DW'(0));
    chk("rst_data_b", odat_b, DW'(0));
    chk("rst_ready_a", DW'(irdy_a), DW'(1));
    chk("rst_ready_b", DW'(irdy_b), DW'(ordy[1]));
    chk("rst_cnt_a", DW'({stall_a, bub_a}), DW'(0));
    chk("rst_cnt_b", DW'({stall_b, bub_b}), DW'(0));
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_stall[d] = 0; m_bub[d] = 0; m_acc[d] = 1'b0;
    end
    rst_n = 1'b1;
    iv    = 2'b00;
  endtask

  initial begin
    int n0, n1, j, hits, base;
    logic got;
    rst_n = 1'b0;
    iv = '0; fl = '0; ordy = '0; clr = '0; idat = '0; ictl = '0;
    @(negedge clk);
    do_reset();

    // Streaming: eight beats back to back with the sink always ready.
    n0 = em_dut0.size();
    for (int i = 1; i <= 8; i++) begin
      drv_both(1'b1, DW'(i), 1'b1);
      cycle();
    end
    repeat (2) begin drv_both(1'b0, '0, 1'b1); cycle(); end
    chk("stream_count", DW'(em_dut0.size() - n0), DW'(8));
    for (int i = 0; i < 8 && n0 + i < em_dut0.size(); i++)
      chk($sformatf("stream_beat%0d", i), em_dut0[n0 + i], DW'(i + 1));

    // Backpressure: A held, B in skid, C stalls until release.
    n0   = em_dut0.size();
    base = m_stall[0];
    drv_both(1'b1, DW'('hA), 1'b0); cycle();
    drv_both(1'b1, DW'('hB), 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      drv_both(1'b1, DW'('hC), 1'b0);
      #1 chk("bp_ready_low", DW'(irdy_a), DW'(0));
      cycle();
    end
    #1 chk("bp_stall_cnt", DW'(stall_a), DW'(base + 4));
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      drv_both(1'b1, DW'('hC), 1'b1);
      cycle();
      got = m_acc[0];
    end
    chk("bp_c_accepted", DW'(got), DW'(1));
    repeat (3) begin drv_both(1'b0, '0, 1'b1); cycle(); end
    chk("bp_order_len", DW'(em_dut0.size() - n0), DW'(3));
    if (em_dut0.size() >= n0 + 3) begin
      chk("bp_order0", em_dut0[n0], DW'('hA));
      chk("bp_order1", em_dut0[n0 + 1], DW'('hB));
      chk("bp_order2", em_dut0[n0 + 2], DW'('hC));
    end

    // Flush from a full skid stage while 0xD is offered.
    n0 = em_dut0.size();
    drv_both(1'b1, DW'('hE1), 1'b0); cycle();
    drv_both(1'b1, DW'('hE2), 1'b0); cycle();
    drv_both(1'b1, DW'('hD), 1'b0, 1'b1); cycle();
    drv_both(1'b0, '0, 1'b1);
    #1;
    chk("flush_valid", DW'(ov_a), DW'(0));
    chk("flush_ctrl", DW'(octl_a), DW'(0));
    chk("flush_ready", DW'(irdy_a), DW'(1));
    cycle();
    repeat (3) begin drv_both(1'b0, '0, 1'b1); cycle(); end
    hits = 0;
    for (int i = n0; i < em_dut0.size(); i++)
      if (em_dut0[i] == DW'('hD) || em_dut0[i] == DW'('hE1) || em_dut0[i] == DW'('hE2)) hits++;
    chk("flush_killed_beats", DW'(hits), DW'(0));

    // Saturation of the 4-bit bubble counter, then a clear that coincides with an increment.
    drv_both(1'b0, '0, 1'b1); clr[1] = 1'b1; cycle();
    repeat (20) begin drv_both(1'b0, '0, 1'b1); cycle(); end
    #1 chk("sat_bubble_max", DW'(bub_b), DW'(15));
    drv_both(1'b0, '0, 1'b1); clr = 2'b11; cycle();
    #1 chk("sat_bubble_clr", DW'(bub_b), DW'(0));

    // No-skid stage: out_ready toggles under continuous input.
    n1 = em_dut1.size();
    j  = 0;
    for (int i = 0; i < 12; i++) begin
      drv_both(1'b1, DW'(32'h100 + j), (i % 2) == 0);
      #1;
      if (ov_b) chk("noskid_ready_track", DW'(irdy_b), DW'(ordy[1]));
      cycle();
      if (m_acc[1]) j++;
    end
    repeat (2) begin drv_both(1'b0, '0, 1'b1); cycle(); end
    chk("noskid_count", DW'(em_dut1.size() - n1), DW'(j));
    for (int i = 0; i < j && n1 + i < em_dut1.size(); i++)
      chk($sformatf("noskid_beat%0d", i), em_dut1[n1 + i], DW'(32'h100 + i));

    // Random traffic, with a reset landing in the middle of it.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++)
        drv(d, ($urandom % 4) != 0, rnd_dat(), ($urandom % 3) != 0,
            ($urandom % 20) == 0, ($urandom % 50) == 0);
      cycle();
      if (i == 300) do_reset();
    end
    repeat (4) begin drv_both(1'b0, '0, 1'b1); cycle(); end

    chk("log_len_a", DW'(em_dut0.size()), DW'(em_ref0.size()));
    chk("log_len_b", DW'(em_dut1.size()), DW'(em_ref1.size()));
    for (int i = 0; i < em_dut0.size() && i < em_ref0.size(); i++)
      if (em_dut0[i] !== em_ref0[i]) chk($sformatf("log_a%0d", i), em_dut0[i], em_ref0[i]);
    for (int i = 0; i < em_dut1.size() && i < em_ref1.size(); i++)
      if (em_dut1[i] !== em_ref1[i]) chk($sformatf("log_b%0d", i), em_dut1[i], em_ref1[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the next generation of the fixed EX/MEM latch. It carries a generic data payload and a control field between any two CPU pipeline stages, using a valid/ready handshake. An optional 2-entry skid buffer lets backpressure propagate with a registered ready. It also provides flush with bubble insertion and saturating stall/bubble performance counters.

## Interface
- DATA_W, 128: payload width (e.g. NPC, ALU result, RT data, instruction).
- CTRL_W, 8: control width; layout comes from the shared package.
- SKID_EN, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: performance counter width.

- clk, input, 1: single clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream presents a beat.
- in_ready, output, 1: stage can accept a beat.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control bits.
- flush, input, 1: kill every held beat and the beat presented this cycle.
- out_valid, output, 1: stage holds a valid beat.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: payload of the head beat.
- out_ctrl, output, CTRL_W: control of the head beat, forced to 0 whenever out_valid=0.
- cnt_clr, input, 1: synchronous clear of both counters.
- stall_cnt, output, CNT_W: cycles with out_valid && !out_ready.
- bubble_cnt, output, CNT_W: cycles with !out_valid && out_ready.

## Operation
- Accept when in_valid && in_ready && !flush. Emit when out_valid && out_ready.
- State machine, SKID_EN=1: EMPTY (no beat), ONE (main register valid), TWO (main and skid valid).
  - EMPTY: accept goes to ONE.
  - ONE: accept without emit goes to TWO (beat into skid); emit without accept goes to EMPTY; accept and emit together stay in ONE (main reloads from input).
  - TWO: emit goes to ONE (skid moves to main); no accept is possible (in_ready=0).
- in_ready (SKID_EN=1) = (state != TWO), taken from the registered state only.
- SKID_EN=0: states EMPTY/ONE only; in_ready = !out_valid || out_ready (combinational).
- flush has priority over every other event. Next state is EMPTY, and the input beat that cycle is discarded even if in_ready=1. An emit in the same cycle still counts as consumed downstream.
- Data registers have no clear on flush: out_data keeps its stale value. Only valid bits and the control registers clear.
- Counters saturate at all-ones; they do not wrap. cnt_clr beats increment in the same cycle (result 0). flush does not clear the counters.

## Timing
- Reset (asynchronous, rst_n=0) gives:
  - state EMPTY;
  - out_valid=0, out_ctrl=0, out_data=0;
  - in_ready=1 (SKID_EN=1) or equal to out_ready (SKID_EN=0);
  - stall_cnt=0, bubble_cnt=0.
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- Throughput is 1 beat per cycle while out_ready=1.
- SKID_EN=1: after out_ready falls, in_ready falls one cycle later, and at most one extra beat is absorbed.
- Order is preserved: the skid beat always leaves before any newer beat.
- If reset asserts mid-transfer, all held beats are lost. The first edge after rst_n rises behaves as EMPTY.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY/ONE/TWO);
  - control bit indices CTRL_ZERO, CTRL_BR_LO/HI, CTRL_MEMR, CTRL_MEMW, CTRL_REGW, CTRL_MEM2R;
  - the default CTRL_W.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_ctrl=0, counters 0. With SKID_EN=1 and rst_n=1, in_ready=1 on the first cycle.
- Streaming: 8 beats, data 0x1..0x8, out_ready=1 throughout -> each appears exactly one cycle after acceptance, 8 consecutive out_valid cycles, in order.
- Backpressure (SKID_EN=1): out_ready=0 while sending 0xA, 0xB, 0xC -> 0xA held, 0xB in skid, in_ready=0 so 0xC stalls. stall_cnt increments per cycle. On release, output order is A, B, C.
- Flush: state TWO, assert flush with in_valid=1 (data 0xD) -> next cycle out_valid=0, out_ctrl=0, in_ready=1. 0xD never appears.
- Saturation: CNT_W=4, out_valid=0 and out_ready=1 for 20 cycles -> bubble_cnt=15. cnt_clr pulse -> 0 on the next cycle.
- SKID_EN=0: out_ready toggles 1,0,1 with continuous input -> in_ready tracks out_ready in the same cycle whenever the stage is full; no beat is lost or duplicated.
